// File: rtl/ocm_pkg.sv
// Shared types and constants for the on-chip memory controller.
// The optional checksum feature is selected by OCM_INIT_CHECKSUM_EN in ocm_mem_ctrl.
package ocm_pkg;

    localparam int OCM_DATA_W         = 16;
    localparam int OCM_DEFAULT_ADDR_W = 8;

    typedef enum logic [2:0] {
        S_INIT  = 3'd0,
        S_IDLE  = 3'd1,
        S_RD    = 3'd2,
        S_RDACK = 3'd3,
        S_WRACK = 3'd4
    } ocm_state_t;

endpackage

// File: rtl/ocm_mem_ctrl_ram.sv
// Single-port synchronous RAM with a registered (one-cycle) read port.
// Contents are deliberately not reset.
module ocm_sync_ram
    import ocm_pkg::*;
#(
    parameter int ADDR_W = OCM_DEFAULT_ADDR_W
) (
    input  logic                  Clk,
    input  logic [ADDR_W-1:0]     addr,
    input  logic                  we,
    input  logic [OCM_DATA_W-1:0] wdata,
    output logic [OCM_DATA_W-1:0] rdata
);

    logic [OCM_DATA_W-1:0] mem [2**ADDR_W];

    always_ff @(posedge Clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end
        rdata <= mem[addr];
    end

endmodule

// File: rtl/ocm_mem_ctrl.sv
// Owns the on-chip RAM: loader-only until INIT_WORDS writes, then serves the CPU port.
// Define OCM_INIT_CHECKSUM_EN to add the init_checksum output.
module ocm_mem_ctrl
    import ocm_pkg::*;
#(
    parameter int ADDR_W     = OCM_DEFAULT_ADDR_W,
    parameter int INIT_WORDS = 256
) (
    input  logic                  Clk,
    input  logic                  Reset,
    input  logic [15:0]           init_addr,
    input  logic                  init_wren,
    input  logic [OCM_DATA_W-1:0] init_data,
    input  logic [15:0]           cpu_addr,
    input  logic                  cpu_ce,
    input  logic                  cpu_we,
    input  logic                  cpu_oe,
    input  logic [OCM_DATA_W-1:0] cpu_wdata,
    output logic [OCM_DATA_W-1:0] cpu_rdata,
    output logic                  cpu_ready,
    output logic                  init_done,
`ifdef OCM_INIT_CHECKSUM_EN
    output logic [15:0]           init_checksum,
`endif
    output ocm_state_t            state
);

    localparam int CNT_W = $clog2(INIT_WORDS + 1);

    ocm_state_t            state_next;
    logic [CNT_W-1:0]      init_cnt;
    logic [ADDR_W-1:0]     addr_q;
    logic                  oor_q;
    logic [ADDR_W-1:0]     ram_addr;
    logic                  ram_we;
    logic [OCM_DATA_W-1:0] ram_wdata;
    logic [OCM_DATA_W-1:0] ram_rdata;
    logic [OCM_DATA_W-1:0] rdata_hold;
    logic                  init_in_range;
    logic                  cpu_in_range;
    logic                  init_fire;
    logic                  init_last;
    logic                  rd_accept;

    assign init_in_range = ({16'b0, init_addr} < (32'd1 << ADDR_W));
    assign cpu_in_range  = ({16'b0, cpu_addr} < (32'd1 << ADDR_W));
    assign init_fire     = (state == S_INIT) && init_wren;
    assign init_last     = init_fire && (init_cnt == CNT_W'(INIT_WORDS - 1));
    assign rd_accept     = (state == S_IDLE) && cpu_ce && !cpu_we && cpu_oe;

    always_comb begin
        state_next = state;
        case (state)
            S_INIT:  if (init_last) state_next = S_IDLE;
            S_IDLE: begin
                if (cpu_ce && cpu_we)      state_next = S_WRACK;
                else if (cpu_ce && cpu_oe) state_next = S_RD;
            end
            S_RD:    state_next = S_RDACK;
            S_RDACK: state_next = S_IDLE;
            S_WRACK: state_next = S_IDLE;
            default: state_next = S_INIT;
        endcase
    end

    // RAM port belongs to the loader in S_INIT and to the CPU otherwise.
    always_comb begin
        ram_addr  = cpu_addr[ADDR_W-1:0];
        ram_we    = 1'b0;
        ram_wdata = cpu_wdata;
        case (state)
            S_INIT: begin
                ram_addr  = init_addr[ADDR_W-1:0];
                ram_we    = init_fire && init_in_range;
                ram_wdata = init_data;
            end
            S_IDLE:  ram_we = cpu_ce && cpu_we && cpu_in_range;
            S_RD:    ram_addr = addr_q;
            default: ram_we = 1'b0;
        endcase
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state      <= S_INIT;
            init_cnt   <= '0;
            init_done  <= 1'b0;
            addr_q     <= '0;
            oor_q      <= 1'b0;
            rdata_hold <= '0;
        end else begin
            state <= state_next;
            if (init_fire) init_cnt <= init_cnt + CNT_W'(1);
            if (init_last) init_done <= 1'b1;
            if (rd_accept) begin
                addr_q <= cpu_addr[ADDR_W-1:0];
                oor_q  <= !cpu_in_range;
            end
            if (state == S_RDACK) rdata_hold <= cpu_rdata;
        end
    end

`ifdef OCM_INIT_CHECKSUM_EN
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            init_checksum <= '0;
        end else if (init_fire) begin
            init_checksum <= init_checksum + init_data;
        end
    end
`endif

    // Read data comes straight from the RAM register during S_RDACK, then is held.
    assign cpu_ready = (state == S_RDACK) || (state == S_WRACK);
    assign cpu_rdata = (state == S_RDACK) ? (oor_q ? '0 : ram_rdata) : rdata_hold;

    ocm_sync_ram #(.ADDR_W(ADDR_W)) u_ram (
        .Clk   (Clk),
        .addr  (ram_addr),
        .we    (ram_we),
        .wdata (ram_wdata),
        .rdata (ram_rdata)
    );

endmodule

// File: tb/tb_ocm_mem_ctrl.sv
// Scoreboard bench for ocm_mem_ctrl: load, CPU reads/writes, range, priority, mid-op reset.
module tb_ocm_mem_ctrl;
    import ocm_pkg::*;

    logic        Clk = 1'b0;
    logic        Reset = 1'b1;
    logic [15:0] init_addr = '0;
    logic        init_wren = 1'b0;
    logic [15:0] init_data = '0;
    logic [15:0] cpu_addr = '0;
    logic        cpu_ce = 1'b0;
    logic        cpu_we = 1'b0;
    logic        cpu_oe = 1'b0;
    logic [15:0] cpu_wdata = '0;
    logic [15:0] cpu_rdata;
    logic        cpu_ready;
    logic        init_done;
`ifdef OCM_INIT_CHECKSUM_EN
    logic [15:0] init_checksum;
`endif
    ocm_state_t  state;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    logic [15:0] exp_q[$];
    bit          exp_rd_q[$];
    int          exp_cyc_q[$];

    ocm_mem_ctrl dut (
        .Clk       (Clk),
        .Reset     (Reset),
        .init_addr (init_addr),
        .init_wren (init_wren),
        .init_data (init_data),
        .cpu_addr  (cpu_addr),
        .cpu_ce    (cpu_ce),
        .cpu_we    (cpu_we),
        .cpu_oe    (cpu_oe),
        .cpu_wdata (cpu_wdata),
        .cpu_rdata (cpu_rdata),
        .cpu_ready (cpu_ready),
        .init_done (init_done),
`ifdef OCM_INIT_CHECKSUM_EN
        .init_checksum (init_checksum),
`endif
        .state     (state)
    );

    // Clock / reset infrastructure
    always #5 Clk = ~Clk;
    always @(posedge Clk) cyc <= cyc + 1;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: every ready pulse must match the oldest queued expectation.
    always @(negedge Clk) begin
        if (cpu_ready) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_ready: cycle %0d rdata %h", cyc, cpu_rdata);
            end else begin
                logic [15:0] e;
                bit          rd;
                int          ec;
                e  = exp_q.pop_front();
                rd = exp_rd_q.pop_front();
                ec = exp_cyc_q.pop_front();
                if (cyc != ec || (rd && cpu_rdata !== e)) begin
                    errors++;
                    $display("FAIL ready_response: cycle %0d rdata %h, expected cycle %0d rdata %h (read=%0d)",
                             cyc, cpu_rdata, ec, e, rd);
                end
            end
        end
    end

    // Driver tasks
    task automatic wait_drain();
        for (int k = 0; k < 10 && exp_q.size() != 0; k++) @(negedge Clk);
        if (exp_q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL ready_timeout: %0d responses outstanding, expected 0", exp_q.size());
            exp_q.delete();
            exp_rd_q.delete();
            exp_cyc_q.delete();
        end
    endtask

    task automatic cpu_req(input logic we, input logic oe, input logic [15:0] addr,
                           input logic [15:0] wdata, input logic [15:0] rexp);
        @(posedge Clk); #1;
        cpu_ce = 1'b1; cpu_we = we; cpu_oe = oe; cpu_addr = addr; cpu_wdata = wdata;
        exp_q.push_back(rexp);
        exp_rd_q.push_back(!we);
        exp_cyc_q.push_back(cyc + (we ? 1 : 2));
        @(posedge Clk); #1;
        cpu_ce = 1'b0; cpu_we = 1'b0; cpu_oe = 1'b0;
        wait_drain();
    endtask

    task automatic load_word(input logic [15:0] a, input logic [15:0] d);
        @(posedge Clk); #1;
        init_wren = 1'b1; init_addr = a; init_data = d;
    endtask

    task automatic finish_load();
        check("init_done_before_last", 16'(init_done), 16'h0);
        @(posedge Clk); #1;
        init_wren = 1'b0;
        cpu_ce = 1'b0; cpu_we = 1'b0; cpu_oe = 1'b0;
        check("init_done_after_last", 16'(init_done), 16'h1);
        check("state_after_load", 16'(state), 16'(S_IDLE));
    endtask

    initial begin
        @(negedge Clk);
        check("reset_state", 16'(state), 16'(S_INIT));
        check("reset_init_done", 16'(init_done), 16'h0);
        check("reset_ready", 16'(cpu_ready), 16'h0);
        check("reset_rdata", cpu_rdata, 16'h0000);
        @(posedge Clk); #1;
        Reset = 1'b0;

        // Load with a CPU write held active the whole time; it must be ignored.
        cpu_ce = 1'b1; cpu_we = 1'b1; cpu_addr = 16'h0005; cpu_wdata = 16'hFFFF;
        for (int i = 0; i < 256; i++) load_word(16'(i), 16'(i) ^ 16'hA5A5);
        finish_load();

        // Loader writes after completion are ignored.
        @(posedge Clk); #1;
        init_wren = 1'b1; init_addr = 16'h0010; init_data = 16'hDEAD;
        @(posedge Clk); #1;
        init_wren = 1'b0;

        cpu_req(1'b0, 1'b1, 16'h0010, 16'h0000, 16'hA5B5);
        cpu_req(1'b0, 1'b1, 16'h0005, 16'h0000, 16'hA5A0);
        cpu_req(1'b1, 1'b0, 16'h00FE, 16'h1234, 16'h0000);
        cpu_req(1'b0, 1'b1, 16'h00FE, 16'h0000, 16'h1234);
        cpu_req(1'b1, 1'b0, 16'h0100, 16'hBEEF, 16'h0000);
        cpu_req(1'b0, 1'b1, 16'h0100, 16'h0000, 16'h0000);
        cpu_req(1'b0, 1'b1, 16'h0000, 16'h0000, 16'hA5A5);
        cpu_req(1'b1, 1'b1, 16'h0003, 16'h7777, 16'h0000);
        cpu_req(1'b0, 1'b1, 16'h0003, 16'h0000, 16'h7777);

        // ce without we/oe: no transition, no ready.
        @(posedge Clk); #1;
        cpu_ce = 1'b1; cpu_addr = 16'h0003;
        @(posedge Clk); #1;
        cpu_ce = 1'b0;
        check("ignored_req_state", 16'(state), 16'(S_IDLE));
        check("rdata_hold", cpu_rdata, 16'h7777);

        // Mid-operation reset while in S_RD.
        @(posedge Clk); #1;
        cpu_ce = 1'b1; cpu_oe = 1'b1; cpu_addr = 16'h0010;
        @(posedge Clk); #1;
        cpu_ce = 1'b0; cpu_oe = 1'b0;
        check("state_in_rd", 16'(state), 16'(S_RD));
        Reset = 1'b1;
        #1;
        check("midop_state", 16'(state), 16'(S_INIT));
        check("midop_init_done", 16'(init_done), 16'h0);
        check("midop_ready", 16'(cpu_ready), 16'h0);
        repeat (3) @(posedge Clk);
        #1;
        Reset = 1'b0;
        check("post_reset_state", 16'(state), 16'(S_INIT));

        // Reload with data 1..256; one write is out of range (dropped, still counted).
        for (int i = 0; i < 256; i++)
            load_word((i == 7) ? 16'h0107 : 16'(i), 16'(i + 1));
        finish_load();
`ifdef OCM_INIT_CHECKSUM_EN
        check("init_checksum", init_checksum, 16'h8080);
`endif
        cpu_req(1'b0, 1'b1, 16'h0007, 16'h0000, 16'hA5A2);
        cpu_req(1'b0, 1'b1, 16'h0008, 16'h0000, 16'h0009);
        cpu_req(1'b0, 1'b1, 16'h0010, 16'h0000, 16'h0011);
        repeat (3) @(posedge Clk);
        #1;
        check("final_rdata_hold", cpu_rdata, 16'h0011);
        check("final_ready_low", 16'(cpu_ready), 16'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
